// File: rtl/pipe_arb_pkg.sv
// Shared encodings for the pipeline memory arbiter: FSM states, transaction owner, counter width.
package pipe_arb_pkg;

  localparam int unsigned LatCntW = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

endpackage

// File: rtl/pipe_arb_lat_cnt.sv
// Memory latency counter: load to 1 on a grant, count up to MEM_LAT, flag done at MEM_LAT.
module pipe_arb_lat_cnt
  import pipe_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  input  logic clear_i,
  output logic done_o
);

  localparam logic [LatCntW-1:0] LatMax = LatCntW'(MEM_LAT);

  logic [LatCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LatCntW'(1);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LatMax)) begin
      // Stops at LatMax so the 4-bit counter can never wrap.
      cnt_d = cnt_q + LatCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LatMax);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one fixed-latency memory between IF fetch and MEM-stage data ports, data first.
// Optional fetch anti-starvation override is enabled by defining PIPE_ARB_FAIRNESS_EN.
module pipe_mem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_d
);

  if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_lat
    $error("pipe_mem_arbiter: MEM_LAT must be 1..15");
  end
  if (MAX_STARVE < 1) begin : g_bad_starve
    $error("pipe_mem_arbiter: MAX_STARVE must be at least 1");
  end

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   lat_done, lat_load, lat_inc, lat_clear;
  logic   rsp, can_grant, pick_if, fetch_first;

  pipe_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (lat_load),
    .inc_i   (lat_inc),
    .clear_i (lat_clear),
    .done_o  (lat_done)
  );

`ifdef PIPE_ARB_FAIRNESS_EN
  localparam int unsigned StarveW = (MAX_STARVE > 3) ? $clog2(MAX_STARVE + 1) : 2;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_STARVE);

  logic [StarveW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign fetch_first = (starve_q == StarveMax);
`else
  assign fetch_first = 1'b0;
`endif

  // The memory is free when idle or in the cycle the current access returns its data.
  assign rsp       = ~reset & (state_q == StWait) & lat_done;
  assign can_grant = ~reset & ((state_q == StIdle) | lat_done);
  assign pick_if   = if_req & (~d_req | fetch_first);

  always_comb begin
    if_gnt    = can_grant & pick_if;
    d_gnt     = can_grant & d_req & ~pick_if;
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
    if_rvalid = rsp & (owner_q == OwnIf);
    d_rvalid  = rsp & (owner_q == OwnD);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    stall_if  = if_req & ~if_rvalid;
    stall_d   = d_req & ~d_rvalid;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_load  = 1'b0;
    lat_inc   = 1'b0;
    lat_clear = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_en) begin
          state_d  = StWait;
          owner_d  = d_gnt ? OwnD : OwnIf;
          lat_load = 1'b1;
        end
      end
      StWait: begin
        if (!lat_done) begin
          lat_inc = 1'b1;
        end else if (mem_en) begin
          owner_d  = d_gnt ? OwnD : OwnIf;
          lat_load = 1'b1;
        end else begin
          state_d   = StIdle;
          owner_d   = OwnNone;
          lat_clear = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule
